sbs_stream_gen: RTL and testbench
=================================

// Module: sbs_stream_gen
// PURPOSE
//  Sequential stochastic-bitstream generator that feeds the SC multiplier operand path.
//  Latches an unsigned WIDTH-bit magnitude on start.
//  Compares it against a maximal-length Galois LFSR for LEN cycles, one bit per cycle.
//  Fills a LEN-bit parallel bitstream and holds done until the next start.
//  Exactly a ones are produced, so the multiplier's AND/accumulate stage sees an unbiased operand.
// PARAMETERS
//  WIDTH      8      magnitude / LFSR width
//  LEN        255    bitstream length; fixed at 2**WIDTH-1
//  LFSR_SEED  8'h01  LFSR load value on start; must be non-zero; distinct per operand instance
//  TAPS       8'hB8  Galois feedback mask (x^8+x^6+x^5+x^4+1, maximal)
// PORTS
//  clk     in   1      clock, rising edge
//  rst     in   1      reset, synchronous, active-low
//  start   in   1      begin a new stream; honoured only in IDLE or DONE
//  a       in   WIDTH  magnitude, sampled on the edge that accepts start
//  a_sbs   out  LEN    generated bitstream; bit i = stream cycle i
//  busy    out  1      high while in RUN
//  done    out  1      level; high in DONE until the next accepted start or reset
// BEHAVIOUR
//  Reset (rst==0 at edge): state=IDLE, a_sbs=0, busy=0, done=0, lfsr=LFSR_SEED, idx=0.
//  Reset has priority over all else; asserting it mid-RUN aborts the stream with no done pulse.
//  FSM IDLE -> RUN on start.
//   - Same edge: a_q<=a, lfsr<=LFSR_SEED, idx<=0, a_sbs<=0, busy<=1.
//  FSM RUN, each edge:
//   - a_sbs[idx] <= (lfsr <= a_q).
//   - lfsr <= (lfsr>>1) ^ (lfsr[0] ? TAPS : 0).
//   - idx <= idx+1.
//   - When idx==LEN-1 is written: state<=DONE, busy<=0, done<=1.
//  FSM DONE -> RUN on start, with the same actions as from IDLE; done drops on that edge.
//  Latency: done rises on the 256th rising edge, counting the start-accepting edge as the 1st.
//  a_sbs is stable and final whenever done==1.
//  Inputs ignored in RUN:
//   - start is ignored; it is neither queued nor restarts the stream.
//   - Changes on a are ignored because a_q is latched.
//  Arithmetic:
//   - lfsr visits every value 1..255 exactly once per stream.
//   - popcount(a_sbs) == a for all a in 0..255: a=0 gives all zeros, a=255 gives all ones.
//  Stream cycle 0 always compares LFSR_SEED, so streams are reproducible per seed.
//  idx is 8 bits wide and never wraps past LEN-1 within a stream.
//  a_sbs bits not yet written during RUN read 0.
// CONFIGURATION
//  SBS_COUNT_EN defined:
//   - Adds output ones_cnt [WIDTH-1:0].
//   - ones_cnt = running count of ones written in the current stream.
//   - ones_cnt is cleared on reset and on accepted start.
//   - ones_cnt is final and equal to a_q when done==1.
//  SBS_COUNT_EN undefined:
//   - The ones_cnt port and its counter are absent.
//   - All other behaviour is identical.
// TESTING
//  T1 seed=1, a=0 -> done exactly 256 edges after start; a_sbs=0; ones_cnt=0.
//  T2 seed=1, a=255 -> a_sbs all ones; ones_cnt=255; busy low with done high.
//  T3 seed=1, a=1 -> a_sbs[0]=1, bits 254:1 =0; a=128 -> popcount 128.
//  T4 pulse start at RUN cycle 100 and change a mid-RUN -> ignored.
//     Stream completes with the original a; done timing is unchanged.
//  T5 rst=0 at RUN cycle 50 -> next edge: IDLE, a_sbs=0, done=0, busy=0.
//     A new start then completes normally.
//  T6 Back-to-back: in DONE, start with a=64 -> done drops the same edge.
//     Restream yields popcount 64 and is bit-identical to a fresh a=64 run.

Source files
------------

// File: rtl/sbs_stream_gen.sv
// -----------------------------------------------------------------------------
// sbs_stream_gen
// Sequential stochastic-bitstream generator for the SC multiplier operand path.
// On an accepted start the WIDTH-bit magnitude a is latched. For LEN cycles the
// latched value is compared with a maximal-length Galois LFSR, one bit per
// cycle, to fill a LEN-bit parallel bitstream. The LFSR visits every non-zero
// state exactly once per stream, so the stream holds exactly a ones.
//
// Ports
//   clk       in   1      clock, rising edge
//   rst       in   1      reset, synchronous, active-low (priority over all)
//   start     in   1      begin a new stream; honoured only in IDLE or DONE
//   a         in   WIDTH  magnitude, sampled on the edge that accepts start
//   a_sbs     out  LEN    bitstream; bit i = stream cycle i
//   busy      out  1      high while a stream is running
//   done      out  1      level; high once the stream is complete, until the
//                         next accepted start or reset
//   ones_cnt  out  WIDTH  running count of ones in the current stream
//                         (present only when SBS_COUNT_EN is defined)
//
// Configuration macro: SBS_COUNT_EN adds the ones_cnt counter and port.
// -----------------------------------------------------------------------------
module sbs_stream_gen #(
   parameter int               WIDTH     = 8,
   parameter int               LEN       = 255,
   parameter logic [WIDTH-1:0] LFSR_SEED = 8'h01,
   parameter logic [WIDTH-1:0] TAPS      = 8'hB8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   output logic [LEN-1:0]   a_sbs,
   output logic             busy,
   output logic             done
`ifdef SBS_COUNT_EN
   ,
   output logic [WIDTH-1:0] ones_cnt
`endif
);

   localparam logic [WIDTH-1:0] LAST_IDX = WIDTH'(LEN - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_s;
   logic             accept_s;
   logic             last_s;
   logic             bit_s;
   logic [WIDTH-1:0] lfsr_nxt_s;

   logic [WIDTH-1:0] a_q_r;
   logic [WIDTH-1:0] lfsr_r;
   logic [WIDTH-1:0] idx_r;
   logic [LEN-1:0]   a_sbs_r;
   logic             busy_r;
   logic             done_r;

   // Comparator bit and Galois LFSR step for the current stream cycle.
   always_comb begin
      bit_s      = (lfsr_r <= a_q_r);
      lfsr_nxt_s = (lfsr_r >> 1) ^ (lfsr_r[0] ? TAPS : {WIDTH{1'b0}});
   end

   // Next-state logic; accept_s marks the edge that latches a new stream.
   always_comb begin
      state_s  = state_r;
      accept_s = 1'b0;
      last_s   = 1'b0;
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_s  = ST_RUN;
               accept_s = 1'b1;
            end else begin
               state_s  = state_r;
            end
         end
         ST_RUN: begin
            // start is deliberately not looked at here: no queueing, no restart.
            if (idx_r == LAST_IDX) begin
               state_s = ST_DONE;
               last_s  = 1'b1;
            end else begin
               state_s = ST_RUN;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Stream datapath: magnitude latch, LFSR, bit index, bitstream and flags.
   always_ff @(posedge clk) begin
      if (!rst) begin
         a_q_r   <= {WIDTH{1'b0}};
         lfsr_r  <= LFSR_SEED;
         idx_r   <= {WIDTH{1'b0}};
         a_sbs_r <= {LEN{1'b0}};
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else if (accept_s) begin
         a_q_r   <= a;
         lfsr_r  <= LFSR_SEED;
         idx_r   <= {WIDTH{1'b0}};
         a_sbs_r <= {LEN{1'b0}};
         busy_r  <= 1'b1;
         done_r  <= 1'b0;
      end else if (state_r == ST_RUN) begin
         a_sbs_r[idx_r] <= bit_s;
         lfsr_r         <= lfsr_nxt_s;
         if (last_s) begin
            // Hold idx at LEN-1 so it never wraps within a stream.
            idx_r  <= idx_r;
            busy_r <= 1'b0;
            done_r <= 1'b1;
         end else begin
            idx_r  <= idx_r + {{(WIDTH-1){1'b0}}, 1'b1};
            busy_r <= 1'b1;
            done_r <= 1'b0;
         end
      end else begin
         a_q_r   <= a_q_r;
         lfsr_r  <= lfsr_r;
         idx_r   <= idx_r;
         a_sbs_r <= a_sbs_r;
         busy_r  <= busy_r;
         done_r  <= done_r;
      end
   end

   assign a_sbs = a_sbs_r;
   assign busy  = busy_r;
   assign done  = done_r;

`ifdef SBS_COUNT_EN
   logic [WIDTH-1:0] ones_cnt_r;

   // Running count of ones written in the current stream.
   always_ff @(posedge clk) begin
      if (!rst) begin
         ones_cnt_r <= {WIDTH{1'b0}};
      end else if (accept_s) begin
         ones_cnt_r <= {WIDTH{1'b0}};
      end else if (state_r == ST_RUN) begin
         ones_cnt_r <= ones_cnt_r + {{(WIDTH-1){1'b0}}, bit_s};
      end else begin
         ones_cnt_r <= ones_cnt_r;
      end
   end

   assign ones_cnt = ones_cnt_r;
`else
   // Counter build option disabled: no ones_cnt port or counter.
`endif

endmodule

// File: tb/tb_sbs_stream_gen.sv
// Scoreboard bench for sbs_stream_gen: stimulus pushes expected stream records,
// a negedge monitor pops and checks one record on every rising edge of done.
module tb_sbs_stream_gen;
   localparam int W = 8;
   localparam int L = 255;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [L-1:0] a_sbs;
   logic         busy;
   logic         done;
`ifdef SBS_COUNT_EN
   logic [W-1:0] ones_cnt;
`endif

   always #5 clk = ~clk;

   sbs_stream_gen #(
      .WIDTH(8), .LEN(255), .LFSR_SEED(8'h01), .TAPS(8'hB8)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .a_sbs (a_sbs),
      .busy  (busy),
      .done  (done)
`ifdef SBS_COUNT_EN
      ,
      .ones_cnt (ones_cnt)
`endif
   );

   // kind: 0 popcount only, 1 exact stream, 2 capture reference, 3 match reference
   typedef struct {
      logic [W-1:0] a;
      int           acc_cyc;
      int           kind;
      logic [L-1:0] exp;
   } rec_t;

   rec_t         sbq[$];
   int           total = 0;
   int           bad   = 0;
   int           cyc   = 0;
   logic [L-1:0] ref_sbs = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk_vec(input string name, input logic [L-1:0] act, input logic [L-1:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, req);
      end
   endtask

   // Monitor: on each rising edge of done, pop the oldest record and check it.
   initial begin
      logic prev_done;
      rec_t r;
      prev_done = 1'b0;
      forever begin
         @(negedge clk);
         if (done === 1'b1 && prev_done !== 1'b1) begin
            if (sbq.size() == 0) begin
               chk_int("unexpected_done", 1, 0);
            end else begin
               r = sbq.pop_front();
               chk_int("done_latency", cyc, r.acc_cyc + 255);
               chk_int("popcount", $countones(a_sbs), int'(r.a));
               chk_int("busy_low_at_done", int'(busy), 0);
`ifdef SBS_COUNT_EN
               chk_int("ones_cnt", int'(ones_cnt), int'(r.a));
`endif
               case (r.kind)
                  1: chk_vec("exact_stream", a_sbs, r.exp);
                  2: ref_sbs = a_sbs;
                  3: chk_vec("restream_ref", a_sbs, ref_sbs);
                  default: ;
               endcase
            end
         end
         prev_done = done;
      end
   end

   // Issue one start; returns at the negedge after the accepting edge.
   task automatic go(input logic [W-1:0] av, input int kind, input logic [L-1:0] exp);
      rec_t r;
      @(negedge clk);
      a     = av;
      start = 1'b1;
      r.a       = av;
      r.acc_cyc = cyc + 1;
      r.kind    = kind;
      r.exp     = exp;
      sbq.push_back(r);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (done !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (done !== 1'b1) chk_int("done_timeout", 0, 1);
      @(negedge clk);
   endtask

   initial begin
      rst   = 1'b0;
      start = 1'b0;
      a     = '0;
      repeat (3) @(negedge clk);
      chk_vec("reset_sbs", a_sbs, '0);
      chk_int("reset_busy", int'(busy), 0);
      chk_int("reset_done", int'(done), 0);
`ifdef SBS_COUNT_EN
      chk_int("reset_cnt", int'(ones_cnt), 0);
`endif
      rst = 1'b1;

      // T1: a=0 -> all zeros
      go(8'd0, 1, '0);
      chk_int("t1_busy_run", int'(busy), 1);
      chk_int("t1_done_run", int'(done), 0);
      wait_done();

      // T2: a=255 -> all ones, done held with busy low
      go(8'd255, 1, '1);
      wait_done();
      chk_int("t2_done_held", int'(done), 1);
      chk_int("t2_busy_held", int'(busy), 0);

      // T3: a=1 -> only bit 0 (seed 1 <= 1); a=128 -> popcount 128
      go(8'd1, 1, 255'd1);
      wait_done();
      go(8'd128, 0, '0);
      chk_vec("t3_cleared_on_start", a_sbs, '0);
      wait_done();

      // T4: start pulse and a change mid-RUN are ignored
      go(8'd200, 0, '0);
      repeat (99) @(negedge clk);
      a     = 8'd17;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk_int("t4_busy_after_pulse", int'(busy), 1);
      chk_int("t4_done_after_pulse", int'(done), 0);
      wait_done();

      // T5: reset mid-RUN aborts with no done, then a fresh stream completes
      @(negedge clk);
      a     = 8'd99;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (49) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      chk_vec("t5_abort_sbs", a_sbs, '0);
      chk_int("t5_abort_busy", int'(busy), 0);
      chk_int("t5_abort_done", int'(done), 0);
      repeat (260) @(negedge clk);
      chk_int("t5_stays_idle", int'(done), 0);
      go(8'd5, 0, '0);
      wait_done();

      // T6: back-to-back restart from DONE with a=64 matches a fresh a=64 run
      go(8'd64, 2, '0);
      wait_done();
      go(8'd64, 3, '0);
      chk_int("t6_done_drop", int'(done), 0);
      chk_int("t6_busy_rise", int'(busy), 1);
      wait_done();

      chk_int("queue_drained", sbq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
